// File: rtl/mcycle_stall_if.sv
// mcycle_stall_if: decoder/datapath handshake bundle for the MCycle stall scheduler
interface mcycle_stall_if;
   logic       Start;
   logic       MCycleOp;
   logic       DivisorZero;
   logic       Busy;
   logic       UnitInit;
   logic       UnitStep;
   logic       Done;
   logic       OpLatched;
   logic       DivZero;
   logic [7:0] StepCount;
   modport master (
      output Start, MCycleOp, DivisorZero,
      input  Busy, UnitInit, UnitStep, Done, OpLatched, DivZero, StepCount
   );
   modport slave (
      input  Start, MCycleOp, DivisorZero,
      output Busy, UnitInit, UnitStep, Done, OpLatched, DivZero, StepCount
   );
endinterface

// File: rtl/mcycle_stall_scheduler.sv
// mcycle_stall_scheduler: sequences MCycle init/step, holds the PC with Busy, retires with a one-cycle Done.
// Optional MCYCLE_DIVZERO_SKIP_EN: a divide by zero skips all step cycles and flags DivZero.
module mcycle_stall_scheduler #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = WIDTH,
   parameter int DIV_CYCLES = 32
) (
   input logic           CLK,
   input logic           Reset,
   mcycle_stall_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [7:0] MUL_T = 8'(MUL_CYCLES);
   localparam logic [7:0] DIV_T = 8'(DIV_CYCLES);
   state_t     state_q, state_d;
   logic [7:0] step_q, step_d, target_q, target_d;
   logic       op_q, op_d, dz_q, dz_d;
   logic       go, skip;
   // Gated by Reset so the stall stays low while reset is asserted with Start held
   assign go = bus.Start & Reset & (state_q == IDLE);
`ifdef MCYCLE_DIVZERO_SKIP_EN
   assign skip = bus.MCycleOp & bus.DivisorZero;
`else
   logic unused_dz;
   assign skip      = 1'b0;
   assign unused_dz = bus.DivisorZero;
`endif
   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      target_d = target_q;
      op_d     = op_q;
      dz_d     = dz_q;
      case (state_q)
         IDLE: if (go) begin
            state_d  = skip ? DONE : RUN;
            step_d   = 8'd0;
            target_d = bus.MCycleOp ? DIV_T : MUL_T;
            op_d     = bus.MCycleOp;
            dz_d     = skip;
         end
         RUN: begin
            step_d  = step_q + 8'd1;
            state_d = (step_q == target_q - 8'd1) ? DONE : RUN;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q  <= IDLE;
         step_q   <= 8'd0;
         target_q <= 8'd0;
         op_q     <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         target_q <= target_d;
         op_q     <= op_d;
         dz_q     <= dz_d;
      end
   end
   assign bus.Busy      = go | (state_q == RUN);
   assign bus.UnitInit  = go;
   assign bus.UnitStep  = state_q == RUN;
   assign bus.Done      = state_q == DONE;
   assign bus.OpLatched = op_q;
   assign bus.DivZero   = dz_q;
   assign bus.StepCount = step_q;
endmodule

// File: tb/tb_mcycle_stall_scheduler.sv
// tb_mcycle_stall_scheduler: directed checks of reset, multiply/divide latency, back-to-back, abort and div-by-zero.
module tb_mcycle_stall_scheduler;
   logic CLK = 1'b0;
   logic Reset;
   int   checks = 0;
   int   errors = 0;
   mcycle_stall_if bus ();
   mcycle_stall_scheduler #(.MUL_CYCLES(32), .DIV_CYCLES(4)) dut (
      .CLK  (CLK),
      .Reset(Reset),
      .bus  (bus)
   );
   always #5 CLK = ~CLK;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask
   initial begin
      bit seen;
      Reset = 1'b0;
      bus.Start = 1'b1;
      bus.MCycleOp = 1'b0;
      bus.DivisorZero = 1'b0;
      repeat (3) begin
         cyc();
         chk("rst_busy", 32'(bus.Busy), 0);
         chk("rst_done", 32'(bus.Done), 0);
         chk("rst_cnt", 32'(bus.StepCount), 0);
      end
      // multiply, 32 steps, MCycleOp toggled mid-run
      Reset = 1'b1;
      #1;
      chk("mul_init", 32'(bus.UnitInit), 1);
      chk("mul_busy0", 32'(bus.Busy), 1);
      for (int k = 1; k <= 32; k++) begin
         cyc();
         if (k == 5) bus.MCycleOp = 1'b1;
         #1;
         chk("mul_step", 32'(bus.UnitStep), 1);
         chk("mul_busy", 32'(bus.Busy), 1);
         chk("mul_noinit", 32'(bus.UnitInit), 0);
         chk("mul_nodone", 32'(bus.Done), 0);
         chk("mul_cnt", 32'(bus.StepCount), 32'(k - 1));
      end
      cyc();
      chk("mul_done", 32'(bus.Done), 1);
      chk("mul_done_busy", 32'(bus.Busy), 0);
      chk("mul_done_step", 32'(bus.UnitStep), 0);
      chk("mul_done_cnt", 32'(bus.StepCount), 32);
      chk("mul_op", 32'(bus.OpLatched), 0);
      bus.Start = 1'b0;
      bus.MCycleOp = 1'b0;
      cyc();
      chk("idle_done", 32'(bus.Done), 0);
      chk("idle_busy", 32'(bus.Busy), 0);
      chk("idle_cnt_hold", 32'(bus.StepCount), 32);
      // back-to-back divides, Start held through DONE
      bus.Start = 1'b1;
      bus.MCycleOp = 1'b1;
      #1;
      chk("div_init", 32'(bus.UnitInit), 1);
      for (int k = 1; k <= 4; k++) begin
         cyc();
         chk("div_step", 32'(bus.UnitStep), 1);
         chk("div_cnt", 32'(bus.StepCount), 32'(k - 1));
      end
      cyc();
      chk("div_done", 32'(bus.Done), 1);
      chk("div_done_init", 32'(bus.UnitInit), 0);
      chk("div_op", 32'(bus.OpLatched), 1);
      chk("div_dz", 32'(bus.DivZero), 0);
      cyc();
      chk("div2_init", 32'(bus.UnitInit), 1);
      chk("div2_busy", 32'(bus.Busy), 1);
      chk("div2_nodone", 32'(bus.Done), 0);
      for (int k = 7; k <= 10; k++) begin
         cyc();
         chk("div2_step", 32'(bus.UnitStep), 1);
         chk("div2_nodone", 32'(bus.Done), 0);
      end
      cyc();
      chk("div2_done", 32'(bus.Done), 1);
      bus.Start = 1'b0;
      cyc();
      chk("div2_idle", 32'(bus.Busy), 0);
      // reset abort at StepCount=10 during a multiply
      bus.Start = 1'b1;
      bus.MCycleOp = 1'b0;
      #1;
      chk("ab_init", 32'(bus.UnitInit), 1);
      for (int k = 1; k <= 11; k++) cyc();
      chk("ab_cnt10", 32'(bus.StepCount), 10);
      Reset = 1'b0;
      #1;
      chk("ab_busy", 32'(bus.Busy), 0);
      chk("ab_step", 32'(bus.UnitStep), 0);
      chk("ab_done", 32'(bus.Done), 0);
      chk("ab_cnt", 32'(bus.StepCount), 0);
      cyc();
      chk("ab_done2", 32'(bus.Done), 0);
      Reset = 1'b1;
      #1;
      chk("ab_reinit", 32'(bus.UnitInit), 1);
      chk("ab_rebusy", 32'(bus.Busy), 1);
      cyc();
      chk("ab_recnt", 32'(bus.StepCount), 0);
      chk("ab_restep", 32'(bus.UnitStep), 1);
      bus.Start = 1'b0;
      seen = 1'b0;
      for (int k = 2; k <= 40 && !seen; k++) begin
         cyc();
         if (bus.Done) begin
            seen = 1'b1;
            chk("ab_done_cycle", 32'(k), 33);
         end
      end
      chk("ab_done_seen", 32'(seen), 1);
      cyc();
      // divide with zero divisor
      bus.Start = 1'b1;
      bus.MCycleOp = 1'b1;
      bus.DivisorZero = 1'b1;
      #1;
      chk("dz_init", 32'(bus.UnitInit), 1);
      chk("dz_busy0", 32'(bus.Busy), 1);
`ifdef MCYCLE_DIVZERO_SKIP_EN
      cyc();
      chk("dz_done", 32'(bus.Done), 1);
      chk("dz_flag", 32'(bus.DivZero), 1);
      chk("dz_nostep", 32'(bus.UnitStep), 0);
      chk("dz_busy1", 32'(bus.Busy), 0);
`else
      for (int k = 1; k <= 4; k++) begin
         cyc();
         chk("dz_step", 32'(bus.UnitStep), 1);
      end
      cyc();
      chk("dz_done", 32'(bus.Done), 1);
      chk("dz_flag", 32'(bus.DivZero), 0);
`endif
      bus.Start = 1'b0;
      bus.DivisorZero = 1'b0;
      cyc();
      chk("dz_idle", 32'(bus.Busy), 0);
      chk("dz_idle_done", 32'(bus.Done), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
